tick_scheduler: RTL and testbench
=================================

# tick_scheduler

Programmable tick generator plus round-robin arbiter that distributes each slow tick to exactly one requesting subsystem. It replaces fixed divide-by-8 enable generation in the game-logic clock domain: one divider produces periodic single-cycle ticks, and each tick is granted to one of `N_REQ` requesters. The granted requester then holds a grant/done handshake. Every output is synchronous to `Clk`.

## Interface
- `N_REQ`, default 4: number of requesters, range 2..8.
- `DIV_W`, default 8: width of the period register and counter.
- `Clk` in 1: system clock.
- `Reset` in 1: asynchronous, active-high.
- `enable` in 1: divider runs when high; counter holds when low.
- `div_load` in 1: single-cycle strobe that loads a new period.
- `div_value` in `DIV_W`: new period minus 1, sampled when `div_load` is high.
- `req` in `N_REQ`: level request, one bit per requester.
- `done` in `N_REQ`: completion strobe. Only the currently granted bit is honoured.
- `missed_clr` in 1: clears `missed`.
- `tick` out 1: single-cycle pulse every `period_reg`+1 enabled cycles.
- `grant` out `N_REQ`: one-hot or zero. Held until the granted requester's `done`.
- `busy` out 1: high while a grant is outstanding.
- `missed` out 1: sticky flag. Set when a tick occurs while `busy` is high.

## Operation
- **Reset values:**
  - `period_reg`=7 (divide-by-8), `counter`=0.
  - `tick`=0, `grant`=0, `busy`=0, `missed`=0.
  - `last`=`N_REQ`-1.
  - State = IDLE.
- **Divider:** on each edge where `enable` is high:
  - If `counter`==`period_reg`: `counter`<=0 and `tick`<=1.
  - Otherwise: `counter`++ and `tick`<=0.
  - When `enable` is low: `counter` holds and `tick`<=0.
- **`div_load`:** `period_reg`<=`div_value`, `counter`<=0, `tick`<=0 on that edge. `div_load` takes priority over `enable`. A value of 0 gives a tick every enabled cycle.
- **FSM, state IDLE:** on an edge with `tick`==1 and `req`!=0:
  - Winner = first set bit of `req`, searching upward from `last`+1 with wrap-around modulo `N_REQ`.
  - `grant`<=onehot(winner), go to GRANT.
  - A tick with `req`==0 is dropped and does not set `missed`.
- **FSM, state GRANT:**
  - On an edge with `done[winner]`==1: `grant`<=0, `last`<=winner, go to IDLE.
  - `done` on non-granted bits is ignored.
  - Deasserting `req[winner]` does not revoke the grant.
- **`missed`:** set on any edge where `tick`==1 and state is GRANT, including the edge on which `done` arrives. `missed_clr` clears it; if set and clear coincide, set wins.
- **`busy`:** equals (state==GRANT). `grant` is nonzero exactly when `busy` is high.
- **Period changes:** `div_load` while in GRANT does not affect the outstanding grant.
- **Reset mid-grant:** all outputs return to reset values asynchronously, and the grant is abandoned.

## Timing
- **First tick:** after reset release with `enable` held high, `tick` is high in the cycle following the 8th rising edge. It then repeats every 8 cycles.
- **Grant latency:** `grant` rises one cycle after `tick` is high (registered on the edge that samples `tick`). Minimum grant width is 1 cycle, when `done` is sampled on the first edge.
- **Release:** `grant` falls on the edge that samples `done`. A new grant requires the next `tick`, so there are no back-to-back grants without an intervening tick.
- **Arbitration:** at most one grant per tick. With all requesters active, service rotates strictly 0,1,2,3,0…

## Structure
- **Package `tick_pkg`:**
  - `state_t` enum {IDLE, GRANT}.
  - Constant `DEFAULT_PERIOD`=7.
  - Function `rr_pick(req, last)` returning the winner index and a valid flag.
- **Sub-module `tick_divider`:** contains `period_reg`, `counter`, `tick`, `div_load` and `enable`.
- **Top `tick_scheduler`:** contains the FSM, `last`, `grant`, `busy` and `missed`.

## Test plan
- **Reset default:** reset, then `enable`=1 and no load. Expect `tick` pulses exactly 8 cycles apart, with the first in the cycle after the 8th edge; `grant` stays 0 with `req`=0.
- **Rotation:** `req`=4'b1111, each requester pulses `done` 2 cycles after its grant. Expect grants 0001, 0010, 0100, 1000, 0001 on successive ticks, each rising 1 cycle after `tick`.
- **Fairness:** `req`=4'b1010, `last`=1. Expect next grant 1000, then 0010.
- **Missed tick:** `div_value`=3 loaded, `req`=4'b0001, `done` withheld for 10 cycles. Expect `missed`=1 after the next tick while `busy`=1. Set with simultaneous `missed_clr` leaves `missed`=1; a lone `missed_clr` clears it.
- **Load mid-count:** `div_load` with `div_value`=0 when `counter`=5. Expect no tick that cycle, then `tick` high on every following cycle.
- **Async reset mid-grant:** assert `Reset` while `grant`=0100. Expect `grant`, `busy` and `missed` to be 0 immediately; after release, the first grant goes to the lowest requesting index.

Source files
------------

// File: rtl/tick_pkg.sv
// rtl/tick_pkg.sv - shared types, constants and round-robin pick for tick_scheduler
package tick_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Divide-by-8 out of reset: period register holds period minus one
  localparam int DEFAULT_PERIOD = 7;

  // Winner index is wide enough for the largest supported requester count (8)
  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } rr_t;

  // Round-robin pick: first set bit of req searching upward from last+1,
  // wrapping modulo n. Requests above bit n-1 are never looked at.
  function automatic rr_t rr_pick(input logic [7:0] req, input logic [2:0] last, input int n);
    rr_t r;
    int  idx;
    r.valid = 1'b0;
    r.idx   = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      idx = (int'(last) + k) % n;
      if (k <= n && !r.valid && req[idx[2:0]]) begin
        r.valid = 1'b1;
        r.idx   = idx[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - programmable divider producing single-cycle ticks
module tick_divider
  import tick_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             enable,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  output logic             tick
);

  logic [DIV_W-1:0] r_period;
  logic [DIV_W-1:0] r_counter;
  logic             r_tick;

  // Count enabled cycles; a load restarts the count and suppresses that cycle's tick
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_period  <= DIV_W'(DEFAULT_PERIOD);
      r_counter <= '0;
      r_tick    <= 1'b0;
    end else if (div_load) begin
      r_period  <= div_value;
      r_counter <= '0;
      r_tick    <= 1'b0;
    end else if (enable) begin
      if (r_counter == r_period) begin
        r_counter <= '0;
        r_tick    <= 1'b1;
      end else begin
        r_counter <= r_counter + 1'b1;
        r_tick    <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - tick generator with round-robin grant/done distribution
module tick_scheduler
  import tick_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DIV_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             enable,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  input  logic             missed_clr,
  output logic             tick,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             missed
);

  logic             w_tick;
  logic [7:0]       w_req8;
  logic [7:0]       w_done8;
  rr_t              w_pick;

  state_t           r_state;
  logic [2:0]       r_last;
  logic [2:0]       r_winner;
  logic [N_REQ-1:0] r_grant;
  logic             r_busy;
  logic             r_missed;

  tick_divider #(
    .DIV_W(DIV_W)
  ) u_divider (
    .Clk      (Clk),
    .Reset    (Reset),
    .enable   (enable),
    .div_load (div_load),
    .div_value(div_value),
    .tick     (w_tick)
  );

  // Requests and completions widened to the package's fixed 8-bit view
  assign w_req8  = 8'(req);
  assign w_done8 = 8'(done);
  assign w_pick  = rr_pick(w_req8, r_last, N_REQ);

  // Grant FSM: a tick hands out one grant, only the winner's done ends it
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_last   <= 3'(N_REQ - 1);
      r_winner <= 3'd0;
      r_grant  <= '0;
      r_busy   <= 1'b0;
      r_missed <= 1'b0;
    end else begin
      // A tick landing on a busy scheduler is lost; setting beats clearing
      if (w_tick && r_state == GRANT) begin
        r_missed <= 1'b1;
      end else if (missed_clr) begin
        r_missed <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_tick && w_pick.valid) begin
            r_winner <= w_pick.idx;
            r_grant  <= N_REQ'(1) << w_pick.idx;
            r_busy   <= 1'b1;
            r_state  <= GRANT;
          end
        end
        GRANT: begin
          if (w_done8[r_winner]) begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_last  <= r_winner;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tick   = w_tick;
  assign grant  = r_grant;
  assign busy   = r_busy;
  assign missed = r_missed;

endmodule

// File: tb/tb_tick_scheduler.sv
// tb/tb_tick_scheduler.sv - self-checking bench for tick_scheduler
module tb_tick_scheduler;

  localparam int N = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       enable = 1'b0;
  logic       div_load = 1'b0;
  logic       missed_clr = 1'b0;
  logic [7:0] div_value = 8'd0;
  logic [3:0] req = 4'd0;
  logic [3:0] done = 4'd0;
  logic       tick;
  logic       busy;
  logic       missed;
  logic [3:0] grant;

  int total = 0;
  int bad = 0;

  // Reference model state
  int   m_per, m_cnt, m_win, m_last;
  logic m_tick, m_busy, m_missed;

  tick_scheduler #(.N_REQ(4), .DIV_W(8)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .enable    (enable),
    .div_load  (div_load),
    .div_value (div_value),
    .req       (req),
    .done      (done),
    .missed_clr(missed_clr),
    .tick      (tick),
    .grant     (grant),
    .busy      (busy),
    .missed    (missed)
  );

  always #5 Clk = ~Clk;

  // Lowest requester above last, otherwise lowest requester overall
  function automatic int rr_ref(input logic [3:0] r, input int last);
    int lo = -1;
    int hi = -1;
    for (int j = N - 1; j >= 0; j--) begin
      if (r[j]) lo = j;
      if (r[j] && j > last) hi = j;
    end
    return (hi >= 0) ? hi : lo;
  endfunction

  function automatic logic [3:0] m_gnt();
    return m_busy ? (4'b0001 << m_win) : 4'b0000;
  endfunction

  task automatic m_reset();
    m_per = 7; m_cnt = 0; m_tick = 1'b0;
    m_busy = 1'b0; m_missed = 1'b0; m_win = 0; m_last = N - 1;
  endtask

  // Advance the model across one rising edge using the inputs currently driven
  task automatic model_edge();
    if (m_busy && m_tick) m_missed = 1'b1;
    else if (missed_clr) m_missed = 1'b0;
    if (m_busy) begin
      if (done[m_win]) begin m_busy = 1'b0; m_last = m_win; end
    end else if (m_tick && req != 4'd0) begin
      m_win = rr_ref(req, m_last);
      m_busy = 1'b1;
    end
    if (div_load) begin m_per = int'(div_value); m_cnt = 0; m_tick = 1'b0; end
    else if (enable) begin
      if (m_cnt == m_per) begin m_cnt = 0; m_tick = 1'b1; end
      else begin m_cnt++; m_tick = 1'b0; end
    end else m_tick = 1'b0;
  endtask

  task automatic step();
    model_edge();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_grant(output logic [3:0] g);
    g = 4'd0;
    for (int c = 0; c < 100 && g == 4'd0; c++) begin
      step();
      g = grant;
    end
    if (g != 4'd0) begin
      done = g; step(); done = 4'd0;
    end
  endtask

  task automatic test_reset();
    int first = -1;
    int second = -1;
    #2 Reset = 1'b1;
    #1;
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", tick); end
    total++; if (grant !== 4'd0) begin bad++; $display("FAIL reset_grant: got %b want 0000", grant); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (missed !== 1'b0) begin bad++; $display("FAIL reset_missed: got %b want 0", missed); end
    @(posedge Clk); @(posedge Clk); #1;
    Reset = 1'b0;
    m_reset();
    enable = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      total++;
      if ({tick, grant, busy, missed} !== {m_tick, m_gnt(), m_busy, m_missed}) begin
        bad++; $display("FAIL reset_cycle%0d: got %b%b%b%b want %b%b%b%b", c, tick, grant, busy, missed, m_tick, m_gnt(), m_busy, m_missed);
      end
      if (tick === 1'b1) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    total++; if (first != 8) begin bad++; $display("FAIL first_tick: got edge %0d want 8", first); end
    total++; if (second - first != 8) begin bad++; $display("FAIL tick_gap: got %0d want 8", second - first); end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int ng = 0;
    int age = 0;
    logic [3:0] prev_grant = grant;
    logic prev_tick = tick;
    req = 4'hF;
    for (int c = 0; c < 300 && !(ng == 5 && busy == 1'b0); c++) begin
      step();
      total++;
      if ({tick, grant, busy, missed} !== {m_tick, m_gnt(), m_busy, m_missed}) begin
        bad++; $display("FAIL rotation_cycle%0d: got %b%b%b%b want %b%b%b%b", c, tick, grant, busy, missed, m_tick, m_gnt(), m_busy, m_missed);
      end
      if (grant != 4'd0 && prev_grant == 4'd0 && ng < 5) begin
        total++; if (grant !== exp_seq[ng]) begin bad++; $display("FAIL rotation_grant%0d: got %b want %b", ng, grant, exp_seq[ng]); end
        total++; if (prev_tick !== 1'b1) begin bad++; $display("FAIL rotation_latency%0d: tick before grant got %b want 1", ng, prev_tick); end
        ng++; age = 0;
      end else if (grant != 4'd0) age++;
      done = (grant != 4'd0 && age == 1) ? grant : 4'd0;
      prev_grant = grant; prev_tick = tick;
    end
    done = 4'd0;
    total++; if (ng != 5) begin bad++; $display("FAIL rotation_count: got %0d grants want 5", ng); end
  endtask

  task automatic test_fairness();
    logic [3:0] g;
    req = 4'b0010; wait_grant(g);
    total++; if (g !== 4'b0010) begin bad++; $display("FAIL fair_setup: got %b want 0010", g); end
    req = 4'b1010; wait_grant(g);
    total++; if (g !== 4'b1000) begin bad++; $display("FAIL fair_first: got %b want 1000", g); end
    wait_grant(g);
    total++; if (g !== 4'b0010) begin bad++; $display("FAIL fair_second: got %b want 0010", g); end
    req = 4'd0;
  endtask

  task automatic test_missed();
    int c;
    div_value = 8'd3; div_load = 1'b1; step(); div_load = 1'b0;
    req = 4'b0001;
    for (c = 0; c < 50 && grant == 4'd0; c++) step();
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL missed_grant: got %b want 0001", grant); end
    for (int k = 0; k < 10; k++) begin
      step();
      total++;
      if ({tick, grant, busy, missed} !== {m_tick, m_gnt(), m_busy, m_missed}) begin
        bad++; $display("FAIL missed_cycle%0d: got %b%b%b%b want %b%b%b%b", k, tick, grant, busy, missed, m_tick, m_gnt(), m_busy, m_missed);
      end
    end
    total++; if ({missed, busy} !== 2'b11) begin bad++; $display("FAIL missed_set: got missed=%b busy=%b want 1 1", missed, busy); end
    for (c = 0; c < 20 && tick != 1'b1; c++) step();
    missed_clr = 1'b1; step();
    total++; if (missed !== 1'b1) begin bad++; $display("FAIL missed_set_wins: got %b want 1", missed); end
    step();
    total++; if (missed !== 1'b0) begin bad++; $display("FAIL missed_clear: got %b want 0", missed); end
    missed_clr = 1'b0;
    req = 4'd0; done = 4'b0001; step(); done = 4'd0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL missed_release: busy got %b want 0", busy); end
  endtask

  task automatic test_load_midcount();
    req = 4'd0;
    div_value = 8'd7; div_load = 1'b1; step(); div_load = 1'b0;
    for (int k = 0; k < 5; k++) step();
    div_value = 8'd0; div_load = 1'b1; step(); div_load = 1'b0;
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL load_no_tick: got %b want 0", tick); end
    for (int k = 0; k < 6; k++) begin
      step();
      total++; if (tick !== 1'b1 || m_tick !== 1'b1) begin bad++; $display("FAIL load_every_cycle%0d: got %b want 1", k, tick); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      enable = ($urandom % 8) != 0;
      div_load = ($urandom % 40) == 0;
      div_value = 8'($urandom % 6);
      req = 4'($urandom % 16);
      done = (($urandom % 4) == 0) ? 4'($urandom % 16) : 4'd0;
      missed_clr = ($urandom % 10) == 0;
      step();
      total++;
      if ({tick, grant, busy, missed} !== {m_tick, m_gnt(), m_busy, m_missed}) begin
        bad++; $display("FAIL random_cycle%0d: got %b%b%b%b want %b%b%b%b", k, tick, grant, busy, missed, m_tick, m_gnt(), m_busy, m_missed);
      end
    end
    enable = 1'b1; div_load = 1'b0; missed_clr = 1'b0; req = 4'd0;
    done = 4'hF; step(); done = 4'd0;
  endtask

  task automatic test_async_reset();
    logic [3:0] g;
    div_value = 8'd3; div_load = 1'b1; step(); div_load = 1'b0;
    req = 4'b0100;
    for (int c = 0; c < 50 && grant == 4'd0; c++) step();
    total++; if (grant !== 4'b0100) begin bad++; $display("FAIL areset_setup: got %b want 0100", grant); end
    for (int k = 0; k < 6; k++) step();
    #2 Reset = 1'b1;
    #1;
    total++; if ({grant, busy, missed} !== 6'd0) begin bad++; $display("FAIL areset_now: got grant=%b busy=%b missed=%b want 0", grant, busy, missed); end
    m_reset();
    @(posedge Clk); #1;
    Reset = 1'b0;
    req = 4'b0110;
    wait_grant(g);
    total++; if (g !== 4'b0010) begin bad++; $display("FAIL areset_first_grant: got %b want 0010", g); end
    req = 4'd0;
  endtask

  initial begin
    m_reset();
    test_reset();
    test_rotation();
    test_fairness();
    test_missed();
    test_load_midcount();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
